// File: rtl/snow64_mem_access_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single external memory bus.
// One request slot per port, round-robin grant, one bus transaction in flight.
module snow64_mem_access_arbiter #(
  parameter int WIDTH__ADDR = 64,
  parameter int WIDTH__LINE = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_instr_req,
  input  logic [WIDTH__ADDR-1:0] in_instr_addr,
  output logic                   out_instr_busy,
  output logic                   out_instr_valid,
  output logic [WIDTH__LINE-1:0] out_instr_data,
  input  logic                   in_data_req,
  input  logic [WIDTH__ADDR-1:0] in_data_addr,
  input  logic                   in_data_we,
  input  logic [WIDTH__LINE-1:0] in_data_wdata,
  output logic                   out_data_busy,
  output logic                   out_data_valid,
  output logic [WIDTH__LINE-1:0] out_data_rdata,
  output logic                   out_mem_req,
  output logic [WIDTH__ADDR-1:0] out_mem_addr,
  output logic                   out_mem_we,
  output logic [WIDTH__LINE-1:0] out_mem_wdata,
  input  logic                   in_mem_valid,
  input  logic [WIDTH__LINE-1:0] in_mem_rdata
);
  typedef enum logic {StIdle = 1'b0, StMemWait = 1'b1} state_t;
  typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_t;

  state_t                 state_q;
  port_t                  last_grant_q;
  port_t                  owner_q;

  logic                   i_pend_q;
  logic [WIDTH__ADDR-1:0] i_addr_q;
  logic                   d_pend_q;
  logic [WIDTH__ADDR-1:0] d_addr_q;
  logic                   d_we_q;
  logic [WIDTH__LINE-1:0] d_wdata_q;

  logic                   instr_valid_q;
  logic [WIDTH__LINE-1:0] instr_data_q;
  logic                   data_valid_q;
  logic [WIDTH__LINE-1:0] data_rdata_q;
  logic                   mem_req_q;
  logic [WIDTH__ADDR-1:0] mem_addr_q;
  logic                   mem_we_q;
  logic [WIDTH__LINE-1:0] mem_wdata_q;

  logic                   grant_any_d;
  port_t                  grant_d;

  // On a tie the port that did not win last time takes the bus.
  always_comb begin
    grant_any_d = i_pend_q || d_pend_q;
    grant_d     = PortI;
    if (d_pend_q && (!i_pend_q || last_grant_q == PortI)) grant_d = PortD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= PortD;
      owner_q       <= PortI;
      i_pend_q      <= 1'b0;
      d_pend_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      mem_req_q     <= 1'b0;

      if (in_instr_req && !i_pend_q) begin
        i_pend_q <= 1'b1;
        i_addr_q <= in_instr_addr;
      end
      if (in_data_req && !d_pend_q) begin
        d_pend_q  <= 1'b1;
        d_addr_q  <= in_data_addr;
        d_we_q    <= in_data_we;
        d_wdata_q <= in_data_wdata;
      end

      case (state_q)
        StIdle: begin
          if (grant_any_d) begin
            mem_req_q    <= 1'b1;
            last_grant_q <= grant_d;
            owner_q      <= grant_d;
            state_q      <= StMemWait;
            if (grant_d == PortD) begin
              mem_addr_q  <= d_addr_q;
              mem_we_q    <= d_we_q;
              mem_wdata_q <= d_wdata_q;
            end else begin
              mem_addr_q  <= i_addr_q;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        StMemWait: begin
          // The slot stays occupied (busy) until the bus completes it.
          if (in_mem_valid) begin
            state_q <= StIdle;
            if (owner_q == PortD) begin
              data_valid_q <= 1'b1;
              data_rdata_q <= d_we_q ? '0 : in_mem_rdata;
              d_pend_q     <= 1'b0;
            end else begin
              instr_valid_q <= 1'b1;
              instr_data_q  <= in_mem_rdata;
              i_pend_q      <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_instr_busy  = i_pend_q;
  assign out_instr_valid = instr_valid_q;
  assign out_instr_data  = instr_data_q;
  assign out_data_busy   = d_pend_q;
  assign out_data_valid  = data_valid_q;
  assign out_data_rdata  = data_rdata_q;
  assign out_mem_req     = mem_req_q;
  assign out_mem_addr    = mem_addr_q;
  assign out_mem_we      = mem_we_q;
  assign out_mem_wdata   = mem_wdata_q;

  // A request while the port is busy is a requester bug; it is dropped.
  a_instr_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(in_instr_req && i_pend_q));
  a_data_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(in_data_req && d_pend_q));

endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// Bench for snow64_mem_access_arbiter: directed vector table, corner sequences,
// and random traffic checked against a cycle-level behavioural model.
module tb_snow64_mem_access_arbiter;
  localparam int AW = 64;
  localparam int LW = 256;
  localparam logic [LW-1:0] Z   = '0;
  localparam logic [LW-1:0] AA  = {32{8'hAA}};
  localparam logic [LW-1:0] L55 = {32{8'h55}};
  localparam logic [LW-1:0] CC  = {32{8'hCC}};
  localparam logic [LW-1:0] L33 = {32{8'h33}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_instr_req;
  logic [AW-1:0] in_instr_addr;
  logic          out_instr_busy;
  logic          out_instr_valid;
  logic [LW-1:0] out_instr_data;
  logic          in_data_req;
  logic [AW-1:0] in_data_addr;
  logic          in_data_we;
  logic [LW-1:0] in_data_wdata;
  logic          out_data_busy;
  logic          out_data_valid;
  logic [LW-1:0] out_data_rdata;
  logic          out_mem_req;
  logic [AW-1:0] out_mem_addr;
  logic          out_mem_we;
  logic [LW-1:0] out_mem_wdata;
  logic          in_mem_valid;
  logic [LW-1:0] in_mem_rdata;

  snow64_mem_access_arbiter #(.WIDTH__ADDR(AW), .WIDTH__LINE(LW)) dut (
    .clk(clk), .rst(rst),
    .in_instr_req(in_instr_req), .in_instr_addr(in_instr_addr),
    .out_instr_busy(out_instr_busy), .out_instr_valid(out_instr_valid),
    .out_instr_data(out_instr_data),
    .in_data_req(in_data_req), .in_data_addr(in_data_addr), .in_data_we(in_data_we),
    .in_data_wdata(in_data_wdata), .out_data_busy(out_data_busy),
    .out_data_valid(out_data_valid), .out_data_rdata(out_data_rdata),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr), .out_mem_we(out_mem_we),
    .out_mem_wdata(out_mem_wdata), .in_mem_valid(in_mem_valid), .in_mem_rdata(in_mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit            pre_rst;
    bit            ireq;
    logic [AW-1:0] iaddr;
    bit            dreq;
    logic [AW-1:0] daddr;
    bit            dwe;
    logic [LW-1:0] dwdata;
    bit            mval;
    logic [LW-1:0] mrdata;
    bit            e_mreq;
    bit            e_bus;
    logic [AW-1:0] e_maddr;
    bit            e_mwe;
    logic [LW-1:0] e_mwdata;
    bit            e_ibusy;
    bit            e_ivalid;
    logic [LW-1:0] e_idata;
    bit            e_dbusy;
    bit            e_dvalid;
    logic [LW-1:0] e_ddata;
  } vec_t;

  localparam int NV = 19;
  vec_t tv[NV];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_instr_req  = 1'b0;
    in_instr_addr = '0;
    in_data_req   = 1'b0;
    in_data_addr  = '0;
    in_data_we    = 1'b0;
    in_data_wdata = '0;
    in_mem_valid  = 1'b0;
    in_mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Random-phase model state: index 0 = instruction port, 1 = data port.
  bit            m_act[2];
  bit            m_inserv[2];
  bit            m_we[2];
  int            m_rc[2];
  int            m_vat[2];
  logic [AW-1:0] m_addr[2];
  logic [LW-1:0] m_wd[2];
  logic [LW-1:0] m_vdata[2];
  bit            m_bus_busy;
  int            m_owner, m_last, m_free_at, m_resp_at;
  logic [LW-1:0] m_resp_d;

  initial begin
    logic [AW-1:0] seen[$];
    logic [AW-1:0] alt_exp[4];
    bit            el[2];
    bit            exp_req;
    bit            expv, expb;
    int            g;

    // ---- reset state
    do_reset();
    chk("rst_instr_busy",  out_instr_busy, 0);
    chk("rst_instr_valid", out_instr_valid, 0);
    chk("rst_instr_data",  out_instr_data, Z);
    chk("rst_data_busy",   out_data_busy, 0);
    chk("rst_data_valid",  out_data_valid, 0);
    chk("rst_data_rdata",  out_data_rdata, Z);
    chk("rst_mem_req",     out_mem_req, 0);
    chk("rst_mem_addr",    out_mem_addr, 0);
    chk("rst_mem_we",      out_mem_we, 0);
    chk("rst_mem_wdata",   out_mem_wdata, Z);

    // ---- directed table: single I read, then simultaneous I read / D store
    tv[0]  = '{1, 1,64'h40,  0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,0,Z,  0,0,Z};
    tv[1]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            1,0,Z,  0,0,Z};
    tv[2]  = '{0, 0,0,       0,0,0,Z,          0,Z,   1,1,64'h40,0,Z,       1,0,Z,  0,0,Z};
    tv[3]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,1,64'h40,0,Z,       1,0,Z,  0,0,Z};
    tv[4]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,1,64'h40,0,Z,       1,0,Z,  0,0,Z};
    tv[5]  = '{0, 0,0,       0,0,0,Z,          1,AA,  0,1,64'h40,0,Z,       1,0,Z,  0,0,Z};
    tv[6]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,1,AA, 0,0,Z};
    tv[7]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,0,Z,  0,0,Z};
    tv[8]  = '{1, 1,64'h100, 1,64'h200,1,L55,  0,Z,   0,0,0,0,Z,            0,0,Z,  0,0,Z};
    tv[9]  = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            1,0,Z,  1,0,Z};
    tv[10] = '{0, 0,0,       0,0,0,Z,          0,Z,   1,1,64'h100,0,Z,      1,0,Z,  1,0,Z};
    tv[11] = '{0, 0,0,       0,0,0,Z,          0,Z,   0,1,64'h100,0,Z,      1,0,Z,  1,0,Z};
    tv[12] = '{0, 0,0,       0,0,0,Z,          1,CC,  0,1,64'h100,0,Z,      1,0,Z,  1,0,Z};
    tv[13] = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,1,CC, 1,0,Z};
    tv[14] = '{0, 0,0,       0,0,0,Z,          0,Z,   1,1,64'h200,1,L55,    0,0,Z,  1,0,Z};
    tv[15] = '{0, 0,0,       0,0,0,Z,          0,Z,   0,1,64'h200,1,L55,    0,0,Z,  1,0,Z};
    tv[16] = '{0, 0,0,       0,0,0,Z,          1,L33, 0,1,64'h200,1,L55,    0,0,Z,  1,0,Z};
    tv[17] = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,0,Z,  0,1,Z};
    tv[18] = '{0, 0,0,       0,0,0,Z,          0,Z,   0,0,0,0,Z,            0,0,Z,  0,0,Z};

    for (int i = 0; i < NV; i++) begin
      if (tv[i].pre_rst) do_reset();
      chk($sformatf("tv%0d_mem_req", i), out_mem_req, tv[i].e_mreq);
      if (tv[i].e_bus) begin
        chk($sformatf("tv%0d_mem_addr", i), out_mem_addr, tv[i].e_maddr);
        chk($sformatf("tv%0d_mem_we", i), out_mem_we, tv[i].e_mwe);
        if (tv[i].e_mwe) chk($sformatf("tv%0d_mem_wdata", i), out_mem_wdata, tv[i].e_mwdata);
      end
      chk($sformatf("tv%0d_instr_busy", i), out_instr_busy, tv[i].e_ibusy);
      chk($sformatf("tv%0d_instr_valid", i), out_instr_valid, tv[i].e_ivalid);
      if (tv[i].e_ivalid) chk($sformatf("tv%0d_instr_data", i), out_instr_data, tv[i].e_idata);
      chk($sformatf("tv%0d_data_busy", i), out_data_busy, tv[i].e_dbusy);
      chk($sformatf("tv%0d_data_valid", i), out_data_valid, tv[i].e_dvalid);
      if (tv[i].e_dvalid) chk($sformatf("tv%0d_data_rdata", i), out_data_rdata, tv[i].e_ddata);
      in_instr_req  = tv[i].ireq;
      in_instr_addr = tv[i].iaddr;
      in_data_req   = tv[i].dreq;
      in_data_addr  = tv[i].daddr;
      in_data_we    = tv[i].dwe;
      in_data_wdata = tv[i].dwdata;
      in_mem_valid  = tv[i].mval;
      in_mem_rdata  = tv[i].mrdata;
      step();
      idle_inputs();
    end

    // ---- both ports re-request on every completion: grants alternate
    do_reset();
    alt_exp[0] = 64'h1000; alt_exp[1] = 64'h2000; alt_exp[2] = 64'h1001; alt_exp[3] = 64'h2001;
    begin
      int vat;
      int ni;
      int nd;
      vat = -1; ni = 1; nd = 1;
      in_instr_req = 1'b1; in_instr_addr = 64'h1000;
      in_data_req  = 1'b1; in_data_addr  = 64'h2000;
      step();
      idle_inputs();
      for (int cyc = 1; cyc < 80 && seen.size() < 4; cyc++) begin
        if (out_mem_req) begin
          seen.push_back(out_mem_addr);
          vat = cyc + 2;
        end
        if (cyc == vat) begin
          in_mem_valid = 1'b1;
          in_mem_rdata = rnd_line();
        end
        if (out_instr_valid) begin
          in_instr_req = 1'b1; in_instr_addr = 64'h1000 + AW'(ni); ni++;
        end
        if (out_data_valid) begin
          in_data_req = 1'b1; in_data_addr = 64'h2000 + AW'(nd); nd++;
        end
        step();
        idle_inputs();
      end
    end
    chk("alt_grant_count", seen.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < seen.size()) chk($sformatf("alt_addr%0d", k), seen[k], alt_exp[k]);

    // ---- in_mem_valid while idle is ignored
    do_reset();
    step();
    in_mem_valid = 1'b1; in_mem_rdata = AA;
    step();
    idle_inputs();
    chk("idle_mv_instr_valid", out_instr_valid, 0);
    chk("idle_mv_data_valid", out_data_valid, 0);
    chk("idle_mv_mem_req", out_mem_req, 0);
    in_data_req = 1'b1; in_data_addr = 64'h500;
    step();
    idle_inputs();
    chk("idle_mv_c1_mem_req", out_mem_req, 0);
    step();
    chk("idle_mv_c2_mem_req", out_mem_req, 1);
    chk("idle_mv_c2_mem_addr", out_mem_addr, 64'h500);
    in_mem_valid = 1'b1; in_mem_rdata = CC;
    step();
    idle_inputs();
    chk("idle_mv_data_valid2", out_data_valid, 1);
    chk("idle_mv_data_rdata", out_data_rdata, CC);

    // ---- reset in the middle of a transaction abandons it
    do_reset();
    in_data_req = 1'b1; in_data_addr = 64'h300;
    step();
    idle_inputs();
    step();
    chk("midrst_mem_req", out_mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_data_busy", out_data_busy, 0);
    chk("midrst_mem_req_clr", out_mem_req, 0);
    in_mem_valid = 1'b1; in_mem_rdata = L33;
    step();
    idle_inputs();
    chk("midrst_late_data_valid", out_data_valid, 0);
    chk("midrst_late_instr_valid", out_instr_valid, 0);
    in_data_req = 1'b1; in_data_addr = 64'h80;
    step();
    idle_inputs();
    chk("midrst_c1_mem_req", out_mem_req, 0);
    step();
    chk("midrst_c2_mem_req", out_mem_req, 1);
    chk("midrst_c2_mem_addr", out_mem_addr, 64'h80);
    chk("midrst_c2_mem_we", out_mem_we, 0);

    // ---- random traffic against the behavioural model
    do_reset();
    for (int p = 0; p < 2; p++) begin
      m_act[p] = 0; m_inserv[p] = 0; m_vat[p] = -1; m_rc[p] = 0;
    end
    m_bus_busy = 0; m_owner = 0; m_last = 1; m_free_at = 0; m_resp_at = 0;
    for (int c = 0; c < 2000; c++) begin
      // A request captured at cycle r can reach the bus at r+2; the bus is free again two cycles after completion.
      exp_req = 0; g = 0;
      if (!m_bus_busy && c >= m_free_at) begin
        for (int p = 0; p < 2; p++) el[p] = m_act[p] && !m_inserv[p] && (m_rc[p] + 2 <= c);
        if (el[0] && el[1]) begin exp_req = 1; g = 1 - m_last; end
        else if (el[0]) begin exp_req = 1; g = 0; end
        else if (el[1]) begin exp_req = 1; g = 1; end
      end
      chk("rnd_mem_req", out_mem_req, exp_req);
      if (exp_req) begin
        chk("rnd_mem_addr", out_mem_addr, m_addr[g]);
        chk("rnd_mem_we", out_mem_we, m_we[g]);
        if (m_we[g]) chk("rnd_mem_wdata", out_mem_wdata, m_wd[g]);
        m_bus_busy = 1; m_owner = g; m_inserv[g] = 1; m_last = g;
        m_resp_at = c + int'($urandom_range(1, 4));
        m_resp_d = rnd_line();
      end else if (m_bus_busy) begin
        chk("rnd_mem_addr_hold", out_mem_addr, m_addr[m_owner]);
      end
      for (int p = 0; p < 2; p++) begin
        expv = (m_vat[p] == c);
        expb = m_act[p] && (m_rc[p] < c) && !expv;
        if (p == 0) begin
          chk("rnd_instr_valid", out_instr_valid, expv);
          chk("rnd_instr_busy", out_instr_busy, expb);
          if (expv) chk("rnd_instr_data", out_instr_data, m_vdata[p]);
        end else begin
          chk("rnd_data_valid", out_data_valid, expv);
          chk("rnd_data_busy", out_data_busy, expb);
          if (expv) chk("rnd_data_rdata", out_data_rdata, m_vdata[p]);
        end
        if (expv) begin
          m_act[p] = 0; m_inserv[p] = 0; m_vat[p] = -1;
        end
      end
      if (m_bus_busy && c == m_resp_at) begin
        in_mem_valid = 1'b1; in_mem_rdata = m_resp_d;
        m_vat[m_owner] = c + 1;
        m_vdata[m_owner] = m_we[m_owner] ? Z : m_resp_d;
        m_bus_busy = 0; m_free_at = c + 2;
      end else if (!m_bus_busy && $urandom_range(0, 7) == 0) begin
        in_mem_valid = 1'b1; in_mem_rdata = rnd_line();
      end
      for (int p = 0; p < 2; p++) begin
        if (!m_act[p] && $urandom_range(0, 2) == 0) begin
          m_act[p] = 1; m_rc[p] = c;
          m_addr[p] = {$urandom(), $urandom()};
          m_we[p] = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          m_wd[p] = (p == 1) ? rnd_line() : Z;
          if (p == 0) begin
            in_instr_req = 1'b1; in_instr_addr = m_addr[p];
          end else begin
            in_data_req = 1'b1; in_data_addr = m_addr[p];
            in_data_we = m_we[p]; in_data_wdata = m_wd[p];
          end
        end
      end
      step();
      idle_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
